// File: rtl/gb_pkg.sv
// gb_pkg: shared constants, state encoding and source-address mapping for the OAM DMA engine.
package gb_pkg;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam int OAM_BYTES = 160;
  localparam logic [15:0] ECHO_OFFSET = 16'h2000;
  typedef enum logic [1:0] {IDLE, DELAY, XFER} dma_state_e;
  // Pages 0xE0 and above mirror work RAM 0x2000 lower.
  function automatic logic [15:0] src_addr(input logic [7:0] hi, input logic [7:0] idx);
    return {hi, idx} - (hi >= 8'hE0 ? ECHO_OFFSET : 16'h0000);
  endfunction
endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: FF46-triggered 160-byte copy from a source page into OAM via the arbiter DMA port.
module oam_dma_engine
  import gb_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  output logic [7:0]  Do_cpu,
  output logic [15:0] A_bus,
  output logic        rd_bus,
  input  logic [7:0]  Di_bus,
  output logic [15:0] A_dma,
  output logic [7:0]  Do_dma,
  output logic        wr_dma,
  output logic        rd_dma,
  input  logic [7:0]  Di_dma,
  output logic        dmaTransfert
);
  // The phase counter doubles as the start-delay counter, so it must cover the longer of the two.
  localparam int PW = $clog2(CYCLES_PER_BYTE) > $clog2(START_DELAY) ? $clog2(CYCLES_PER_BYTE) : $clog2(START_DELAY);
  localparam logic [PW-1:0] PH_LAST = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] DL_LAST = PW'(START_DELAY - 1);
  localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);
  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d, idx_q, idx_d, data_q, data_d;
  logic [PW-1:0] ph_q, ph_d;
  logic start, xfer, slot_end, last, unused_di_dma;
  assign start = wr_cpu && A_cpu == DMA_REG_ADDR;
  assign xfer = state_q == XFER;
  assign slot_end = xfer && ph_q == PH_LAST;
  assign last = slot_end && idx_q == IDX_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q <= 8'h00;
      idx_q <= 8'h00;
      ph_q <= '0;
      data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      idx_q <= idx_d;
      ph_q <= ph_d;
      data_q <= data_d;
    end
  end
  // A register write always wins, aborting any slot in flight before its write phase.
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    idx_d = idx_q;
    ph_d = ph_q;
    data_d = data_q;
    if (start) begin
      state_d = DELAY;
      src_d = Di_cpu;
      idx_d = 8'h00;
      ph_d = '0;
    end else if (state_q == DELAY) begin
      state_d = ph_q == DL_LAST ? XFER : DELAY;
      ph_d = ph_q == DL_LAST ? '0 : ph_q + 1'b1;
    end else if (xfer) begin
      state_d = last ? IDLE : XFER;
      ph_d = slot_end ? '0 : ph_q + 1'b1;
      idx_d = slot_end ? idx_q + 8'd1 : idx_q;
      data_d = ph_q == PW'(1) ? Di_bus : data_q;
    end
  end
  assign rd_bus = xfer && ph_q <= PW'(1);
  assign A_bus = rd_bus ? src_addr(src_q, idx_q) : 16'h0000;
  assign wr_dma = slot_end;
  assign A_dma = slot_end ? OAM_BASE + {8'h00, idx_q} : 16'h0000;
  assign Do_dma = slot_end ? data_q : 8'h00;
  assign rd_dma = 1'b0;
  assign dmaTransfert = state_q != IDLE;
  assign Do_cpu = (rd_cpu && A_cpu == DMA_REG_ADDR) ? src_q : 8'h00;
  assign unused_di_dma = ^Di_dma;
endmodule
